cpu_control_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the 8-bit CPU. Drives memory_address_register

---
 rtl/cpu_control_sequencer_pkg.sv | 40 ++++
 rtl/cpu_control_sequencer_if.sv | 37 +++
 rtl/cpu_control_sequencer_instr_decoder.sv | 28 ++
 rtl/cpu_control_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_control_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_control_sequencer_pkg.sv
// Shared types and constants for the 8-bit CPU control sequencer.
package cpu_control_sequencer_pkg;

   typedef logic [3:0] opcode_t;

   localparam opcode_t OP_NOP = 4'h0;
   localparam opcode_t OP_LDA = 4'h1;
   localparam opcode_t OP_ADD = 4'h2;
   localparam opcode_t OP_SUB = 4'h3;
   localparam opcode_t OP_STA = 4'h4;
   localparam opcode_t OP_JMP = 4'h5;
   localparam opcode_t OP_JZ  = 4'h6;
   localparam opcode_t OP_OUT = 4'h7;
   localparam opcode_t OP_HLT = 4'hF;

   localparam logic [3:0] ALU_ADD_CODE = 4'h0;
   localparam logic [3:0] ALU_SUB_CODE = 4'h1;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_F_ADDR  = 4'd1,
      S_F_INSTR = 4'd2,
      S_DECODE  = 4'd3,
      S_OPERAND = 4'd4,
      S_M_ADDR  = 4'd5,
      S_M_ACC   = 4'd6,
      S_ALU_WB  = 4'd7,
      S_HALT    = 4'd8
   } state_e;

   // Instruction class flags produced by the decoder.
   typedef struct packed {
      logic is_mem;
      logic is_jump;
      logic is_alu;
      logic is_one_byte;
      logic illegal;
   } dec_t;

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Control/status bundle between the sequencer and the CPU datapath.
interface cpu_control_sequencer_if #(
   parameter int DATA_W = 8
) ();
   logic              run;
   logic [DATA_W-1:0] mem_data;
   logic              zero_flag;
   logic              mar_load;
   logic              mar_sel;
   logic              pc_inc;
   logic              pc_load;
   logic              ir_load;
   logic              opnd_load;
   logic              a_load;
   logic              a_sel;
   logic              b_load;
   logic [3:0]        alu_op;
   logic              flag_load;
   logic              ram_we;
   logic              out_load;
   logic              halted;
   logic              illegal_op;

   modport master (
      input  run, mem_data, zero_flag,
      output mar_load, mar_sel, pc_inc, pc_load, ir_load, opnd_load,
             a_load, a_sel, b_load, alu_op, flag_load, ram_we, out_load,
             halted, illegal_op
   );

   modport slave (
      output run, mem_data, zero_flag,
      input  mar_load, mar_sel, pc_inc, pc_load, ir_load, opnd_load,
             a_load, a_sel, b_load, alu_op, flag_load, ram_we, out_load,
             halted, illegal_op
   );
endinterface

// File: rtl/cpu_control_sequencer_instr_decoder.sv
// Combinational opcode classifier used by the sequencer FSM.
module cpu_instr_decoder
   import cpu_control_sequencer_pkg::*;
(
   input  opcode_t opcode,
   output dec_t    dec
);

   // Map the opcode nibble onto instruction class flags.
   always_comb begin
      dec = '0;
      case (opcode)
         OP_NOP, OP_OUT, OP_HLT: dec.is_one_byte = 1'b1;
         OP_LDA, OP_STA:         dec.is_mem      = 1'b1;
         OP_ADD, OP_SUB: begin
            dec.is_mem = 1'b1;
            dec.is_alu = 1'b1;
         end
         OP_JMP, OP_JZ:          dec.is_jump     = 1'b1;
         default: begin
            // Undefined opcodes run as a one-byte NOP.
            dec.illegal     = 1'b1;
            dec.is_one_byte = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute state machine for the 8-bit CPU. Holds only the FSM
// state and a shadow copy of the opcode nibble; the datapath owns PC/IR/A/B.
module cpu_control_sequencer
   import cpu_control_sequencer_pkg::*;
#(
   parameter int         DATA_W  = 8,
   parameter logic [3:0] ALU_ADD = ALU_ADD_CODE,
   parameter logic [3:0] ALU_SUB = ALU_SUB_CODE
) (
   input  logic                   clk,
   input  logic                   reset,
   cpu_control_sequencer_if.master bus
);

   state_e  state_q, state_d;
   opcode_t opcode_q, opcode_d;
   dec_t    dec;

   logic       mar_load;
   logic       mar_sel;
   logic       pc_inc;
   logic       pc_load;
   logic       ir_load;
   logic       opnd_load;
   logic       a_load;
   logic       a_sel;
   logic       b_load;
   logic [3:0] alu_op;
   logic       flag_load;
   logic       ram_we;
   logic       out_load;
   logic       halted;
   logic       illegal_op;

   cpu_instr_decoder u_decoder (
      .opcode (opcode_q),
      .dec    (dec)
   );

   // Next-state and opcode capture; the opcode is latched alongside ir_load.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         S_IDLE:    if (bus.run) state_d = S_F_ADDR;
         S_F_ADDR:  state_d = S_F_INSTR;
         S_F_INSTR: begin
            opcode_d = bus.mem_data[DATA_W-1 -: 4];
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            if (opcode_q == OP_HLT)   state_d = S_HALT;
            else if (dec.is_one_byte) state_d = S_F_ADDR;
            else                      state_d = S_OPERAND;
         end
         S_OPERAND: state_d = dec.is_jump ? S_F_ADDR : S_M_ADDR;
         S_M_ADDR:  state_d = S_M_ACC;
         S_M_ACC:   state_d = dec.is_alu ? S_ALU_WB : S_F_ADDR;
         S_ALU_WB:  state_d = S_F_ADDR;
         S_HALT:    if (bus.run) state_d = S_F_ADDR;
         default:   state_d = S_IDLE;
      endcase
   end

   // State register; asynchronous reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         opcode_q <= OP_NOP;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   // Control strobes decoded from the registered state and opcode.
   always_comb begin
      mar_load   = 1'b0;
      mar_sel    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      ir_load    = 1'b0;
      opnd_load  = 1'b0;
      a_load     = 1'b0;
      a_sel      = 1'b0;
      b_load     = 1'b0;
      alu_op     = ALU_ADD;
      flag_load  = 1'b0;
      ram_we     = 1'b0;
      out_load   = 1'b0;
      halted     = 1'b0;
      illegal_op = 1'b0;
      case (state_q)
         S_F_ADDR: mar_load = 1'b1;
         S_F_INSTR: begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
         end
         S_DECODE: begin
            if (dec.illegal)                illegal_op = 1'b1;
            else if (opcode_q == OP_OUT)    out_load   = 1'b1;
            else if (!dec.is_one_byte)      mar_load   = 1'b1;
         end
         S_OPERAND: begin
            if (opcode_q == OP_JMP) begin
               pc_load = 1'b1;
            end else if (opcode_q == OP_JZ) begin
               // Exactly one of pc_load/pc_inc: taken branch or skip operand.
               pc_load = bus.zero_flag;
               pc_inc  = ~bus.zero_flag;
            end else begin
               opnd_load = 1'b1;
               pc_inc    = 1'b1;
            end
         end
         S_M_ADDR: begin
            mar_load = 1'b1;
            mar_sel  = 1'b1;
         end
         S_M_ACC: begin
            if (opcode_q == OP_LDA)      a_load = 1'b1;
            else if (opcode_q == OP_STA) ram_we = 1'b1;
            else if (dec.is_alu)         b_load = 1'b1;
         end
         S_ALU_WB: begin
            a_load    = 1'b1;
            a_sel     = 1'b1;
            flag_load = 1'b1;
            alu_op    = (opcode_q == OP_SUB) ? ALU_SUB : ALU_ADD;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign bus.mar_load   = mar_load;
   assign bus.mar_sel    = mar_sel;
   assign bus.pc_inc     = pc_inc;
   assign bus.pc_load    = pc_load;
   assign bus.ir_load    = ir_load;
   assign bus.opnd_load  = opnd_load;
   assign bus.a_load     = a_load;
   assign bus.a_sel      = a_sel;
   assign bus.b_load     = b_load;
   assign bus.alu_op     = alu_op;
   assign bus.flag_load  = flag_load;
   assign bus.ram_we     = ram_we;
   assign bus.out_load   = out_load;
   assign bus.halted     = halted;
   assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: a small RAM/datapath model plus per-cycle
// expected control vectors held in a scoreboard queue.
module tb_cpu_control_sequencer;

   typedef struct {
      logic [17:0] vec;
      logic        chk_md;
      logic [7:0]  md;
   } exp_t;

   localparam logic [17:0] V_MAR  = 18'h20000;
   localparam logic [17:0] V_SEL  = 18'h10000;
   localparam logic [17:0] V_PCI  = 18'h08000;
   localparam logic [17:0] V_PCL  = 18'h04000;
   localparam logic [17:0] V_IR   = 18'h02000;
   localparam logic [17:0] V_OPND = 18'h01000;
   localparam logic [17:0] V_ALD  = 18'h00800;
   localparam logic [17:0] V_ASEL = 18'h00400;
   localparam logic [17:0] V_BLD  = 18'h00200;
   localparam logic [17:0] V_FLG  = 18'h00100;
   localparam logic [17:0] V_WE   = 18'h00080;
   localparam logic [17:0] V_OUT  = 18'h00040;
   localparam logic [17:0] V_HLT  = 18'h00020;
   localparam logic [17:0] V_ILL  = 18'h00010;
   localparam logic [17:0] V_SUB  = 18'h00001;

   logic clk;
   logic reset;

   logic [7:0] ram [256];
   logic [7:0] pc, mar, opnd, a, b;
   logic       zf_q;
   logic       zf_ovr_en, zf_ovr;
   logic [7:0] alu_res;
   logic [17:0] obs_vec;

   exp_t       exp_q[$];
   logic [7:0] out_q[$];

   int checks;
   int failures;

   cpu_control_sequencer_if #(.DATA_W(8)) bus ();

   cpu_control_sequencer #(
      .DATA_W  (8),
      .ALU_ADD (4'h0),
      .ALU_SUB (4'h1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_data  = ram[mar];
   assign bus.zero_flag = zf_ovr_en ? zf_ovr : zf_q;
   assign alu_res = (bus.alu_op == 4'h1) ? (a - b) : (a + b);
   assign obs_vec = {bus.mar_load, bus.mar_sel, bus.pc_inc, bus.pc_load,
                     bus.ir_load, bus.opnd_load, bus.a_load, bus.a_sel,
                     bus.b_load, bus.flag_load, bus.ram_we, bus.out_load,
                     bus.halted, bus.illegal_op, bus.alu_op};

   // Datapath/RAM model driven by the sequencer strobes.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc   <= 8'h00;
         mar  <= 8'h00;
         opnd <= 8'h00;
         a    <= 8'h00;
         b    <= 8'h00;
         zf_q <= 1'b0;
      end else begin
         if (bus.mar_load)  mar  <= bus.mar_sel ? opnd : pc;
         if (bus.pc_inc)    pc   <= pc + 8'h01;
         if (bus.pc_load)   pc   <= bus.mem_data;
         if (bus.opnd_load) opnd <= bus.mem_data;
         if (bus.a_load)    a    <= bus.a_sel ? alu_res : bus.mem_data;
         if (bus.b_load)    b    <= bus.mem_data;
         if (bus.flag_load) zf_q <= (alu_res == 8'h00);
         if (bus.ram_we)    ram[mar] <= a;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [17:0] v);
      exp_t e;
      e.vec = v; e.chk_md = 1'b0; e.md = 8'h00;
      exp_q.push_back(e);
   endtask

   task automatic push_md(input logic [17:0] v, input logic [7:0] md);
      exp_t e;
      e.vec = v; e.chk_md = 1'b1; e.md = md;
      exp_q.push_back(e);
   endtask

   task automatic push_fetch();
      push(V_MAR);
      push(V_IR | V_PCI);
   endtask

   task automatic load_prog(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      ram[0] = p0; ram[1] = p1; ram[2] = p2; ram[3] = p3;
   endtask

   task automatic hard_reset();
      run_drive(1'b0);
      zf_ovr_en = 1'b0;
      zf_ovr    = 1'b0;
      reset     = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_drive(input logic v);
      bus.run = v;
   endtask

   // Pop one expected vector per cycle and compare at the falling edge.
   task automatic check_seq(input string name);
      exp_t e;
      int   idx;
      idx = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_vec !== e.vec) begin
            failures++;
            $display("FAIL %s cycle %0d: strobes got %h expected %h", name, idx, obs_vec, e.vec);
         end
         if (e.chk_md) begin
            checks++;
            if (bus.mem_data !== e.md) begin
               failures++;
               $display("FAIL %s cycle %0d: mem_data got %h expected %h", name, idx, bus.mem_data, e.md);
            end
         end
         bus.run = 1'b0;
         idx++;
      end
   endtask

   task automatic start_run();
      @(negedge clk);
      bus.run = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.run = 1'b0;
      zf_ovr_en = 1'b0;
      zf_ovr = 1'b0;
      load_prog(8'h00, 8'h00, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      checks++;
      if (obs_vec !== 18'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected %h", obs_vec, 18'h0);
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (obs_vec !== 18'h0) begin
         failures++;
         $display("FAIL idle_without_run: got %h expected %h", obs_vec, 18'h0);
      end
   endtask

   task automatic test_lda();
      hard_reset();
      load_prog(8'h10, 8'h80, 8'h00, 8'h00);
      ram[8'h80] = 8'h2A;
      start_run();
      push_fetch();
      push(V_MAR);
      push(V_OPND | V_PCI);
      push(V_MAR | V_SEL);
      push_md(V_ALD, 8'h2A);
      push(V_MAR);
      check_seq("lda");
      checks++;
      if (a !== 8'h2A) begin
         failures++;
         $display("FAIL lda_a_reg: got %h expected %h", a, 8'h2A);
      end
   endtask

   task automatic test_sub();
      hard_reset();
      load_prog(8'h30, 8'h81, 8'h00, 8'h00);
      ram[8'h81] = 8'h05;
      start_run();
      push_fetch();
      push(V_MAR);
      push(V_OPND | V_PCI);
      push(V_MAR | V_SEL);
      push_md(V_BLD, 8'h05);
      push(V_ALD | V_ASEL | V_FLG | V_SUB);
      push(V_MAR);
      check_seq("sub");
      checks++;
      if (a !== 8'hFB || zf_q !== 1'b0) begin
         failures++;
         $display("FAIL sub_result: got a=%h z=%b expected a=fb z=0", a, zf_q);
      end
   endtask

   task automatic test_jump();
      logic [7:0] exp_pc [3];
      logic [7:0] ops [3];
      logic       zfs [3];
      ops[0] = 8'h60; zfs[0] = 1'b1; exp_pc[0] = 8'h40;
      ops[1] = 8'h60; zfs[1] = 1'b0; exp_pc[1] = 8'h02;
      ops[2] = 8'h50; zfs[2] = 1'b0; exp_pc[2] = 8'h40;
      for (int t = 0; t < 3; t++) begin
         hard_reset();
         zf_ovr_en = 1'b1;
         zf_ovr    = zfs[t];
         load_prog(ops[t], 8'h40, 8'h00, 8'h00);
         start_run();
         push_fetch();
         push(V_MAR);
         push((exp_pc[t] == 8'h40) ? V_PCL : V_PCI);
         push(V_MAR);
         check_seq("jump");
         checks++;
         if (pc !== exp_pc[t]) begin
            failures++;
            $display("FAIL jump_pc case %0d: got %h expected %h", t, pc, exp_pc[t]);
         end
      end
      zf_ovr_en = 1'b0;
   endtask

   task automatic test_back_to_back_lda_sta();
      hard_reset();
      load_prog(8'h10, 8'h80, 8'h40, 8'h90);
      ram[8'h80] = 8'h5C;
      ram[8'h90] = 8'h11;
      start_run();
      push_fetch();
      push(V_MAR);
      push(V_OPND | V_PCI);
      push(V_MAR | V_SEL);
      push_md(V_ALD, 8'h5C);
      push_fetch();
      push(V_MAR);
      push(V_OPND | V_PCI);
      push(V_MAR | V_SEL);
      push(V_WE);
      push(V_MAR);
      check_seq("lda_sta");
      checks++;
      if (ram[8'h90] !== 8'h5C) begin
         failures++;
         $display("FAIL sta_write: ram[90] got %h expected %h", ram[8'h90], 8'h5C);
      end
   endtask

   task automatic test_halt();
      hard_reset();
      load_prog(8'hF0, 8'h00, 8'h00, 8'h00);
      start_run();
      push_fetch();
      push(18'h0);
      for (int i = 0; i < 20; i++) push(V_HLT);
      check_seq("halt");
      checks++;
      if (pc !== 8'h01) begin
         failures++;
         $display("FAIL halt_pc_hold: got %h expected %h", pc, 8'h01);
      end
      bus.run = 1'b1;
      push(V_MAR);
      push(V_IR | V_PCI);
      check_seq("resume");
      checks++;
      if (mar !== 8'h01) begin
         failures++;
         $display("FAIL resume_fetch_addr: got %h expected %h", mar, 8'h01);
      end
   endtask

   task automatic test_reset_mid_sta_and_illegal();
      hard_reset();
      load_prog(8'h40, 8'h90, 8'h00, 8'h00);
      ram[8'h90] = 8'hEE;
      start_run();
      push_fetch();
      push(V_MAR);
      push(V_OPND | V_PCI);
      push(V_MAR | V_SEL);
      check_seq("sta_pre_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (obs_vec !== 18'h0) begin
         failures++;
         $display("FAIL reset_in_m_acc: got %h expected %h", obs_vec, 18'h0);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (ram[8'h90] !== 8'hEE) begin
         failures++;
         $display("FAIL aborted_write: ram[90] got %h expected %h", ram[8'h90], 8'hEE);
      end
      reset = 1'b1;
      load_prog(8'h95, 8'h00, 8'h00, 8'h00);
      start_run();
      push_fetch();
      push(V_ILL);
      push(V_MAR);
      push(V_IR | V_PCI);
      check_seq("illegal");
   endtask

   task automatic test_program_out();
      bit done;
      hard_reset();
      load_prog(8'h10, 8'h80, 8'h20, 8'h81);
      ram[4] = 8'h70;
      ram[5] = 8'hF0;
      ram[8'h80] = 8'h03;
      ram[8'h81] = 8'h04;
      out_q.push_back(8'h07);
      start_run();
      @(negedge clk);
      bus.run = 1'b0;
      done = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         if (bus.out_load) begin
            checks++;
            if (out_q.size() == 0) begin
               failures++;
               $display("FAIL out_unexpected: got %h expected no out_load", a);
            end else begin
               logic [7:0] e;
               e = out_q.pop_front();
               if (a !== e) begin
                  failures++;
                  $display("FAIL out_value: got %h expected %h", a, e);
               end
            end
         end
         if (bus.halted) done = 1'b1;
      end
      checks++;
      if (!done || out_q.size() != 0) begin
         failures++;
         $display("FAIL program_halt: halted=%b pending_out=%0d expected halted=1 pending_out=0",
                  done, out_q.size());
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      bus.run  = 1'b0;
      test_reset();
      test_lda();
      test_sub();
      test_jump();
      test_back_to_back_lda_sta();
      test_halt();
      test_reset_mid_sta_and_illegal();
      test_program_out();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
